// File: rtl/reset_request_axi_master_if.sv
// AXI4-Lite bus bundle between the reset-request initiator and the reset module's
// register slave. Master drives addresses/data/ready-for-responses; slave answers.
`timescale 1ns/1ps
interface reset_request_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/reset_request_axi_master.sv
// Issues one domain reset request over AXI4-Lite: write control, poll status until
// retired, report a 2-bit completion. Optional poll timeout: RESET_REQ_TIMEOUT_EN.
`timescale 1ns/1ps
module reset_request_axi_master #(
  parameter int          C_M00_AXI_ADDR_WIDTH = 32,
  parameter int          C_M00_AXI_DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR            = 32'h0,
  parameter logic [31:0] CTRL_OFFSET          = 32'h0,
  parameter logic [31:0] STATUS_OFFSET        = 32'h4,
  parameter int          POLL_GAP             = 4,
  parameter int          POLL_LIMIT           = 256
) (
  input  logic                      m00_axi_aclk,
  input  logic                      m00_axi_aresetn,
  input  logic                      req_valid,
  input  logic [2:0]                req_domain,
  output logic                      req_ready,
  output logic                      done_valid,
  output logic [1:0]                done_status,
  reset_request_axi_master_if.master m00_axi
);

  localparam int AW    = C_M00_AXI_ADDR_WIDTH;
  localparam int GAP_W = $clog2(POLL_GAP + 1);
  localparam logic [31:0] CTRL_ADDR   = BASE_ADDR + CTRL_OFFSET;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + STATUS_OFFSET;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_WR_ERR  = 2'b01;
  localparam logic [1:0] ST_RD_ERR  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_BRESP, S_READ, S_RDATA, S_GAP, S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic              aw_done_reg, aw_done_next;
  logic              w_done_reg, w_done_next;
  logic [AW-1:0]     awaddr_reg, awaddr_next;
  logic [AW-1:0]     araddr_reg, araddr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;
  logic [1:0]        status_reg, status_next;
`ifdef RESET_REQ_TIMEOUT_EN
  localparam int POLL_W = $clog2(POLL_LIMIT + 1);
  localparam logic [1:0] ST_TIMEOUT = 2'b11;
  logic [POLL_W-1:0] poll_cnt_reg, poll_cnt_next;
`endif

  logic awvalid_int, wvalid_int, arvalid_int;
  logic aw_fire, w_fire;

  assign awvalid_int = (state_reg == S_WRITE) && !aw_done_reg;
  assign wvalid_int  = (state_reg == S_WRITE) && !w_done_reg;
  assign arvalid_int = (state_reg == S_READ);
  assign aw_fire     = awvalid_int && m00_axi.awready;
  assign w_fire      = wvalid_int && m00_axi.wready;

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state_reg    <= S_IDLE;
      aw_done_reg  <= 1'b0;
      w_done_reg   <= 1'b0;
      awaddr_reg   <= '0;
      araddr_reg   <= '0;
      wdata_reg    <= '0;
      gap_cnt_reg  <= '0;
      status_reg   <= ST_OK;
`ifdef RESET_REQ_TIMEOUT_EN
      poll_cnt_reg <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      aw_done_reg  <= aw_done_next;
      w_done_reg   <= w_done_next;
      awaddr_reg   <= awaddr_next;
      araddr_reg   <= araddr_next;
      wdata_reg    <= wdata_next;
      gap_cnt_reg  <= gap_cnt_next;
      status_reg   <= status_next;
`ifdef RESET_REQ_TIMEOUT_EN
      poll_cnt_reg <= poll_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next    = state_reg;
    aw_done_next  = aw_done_reg;
    w_done_next   = w_done_reg;
    awaddr_next   = awaddr_reg;
    araddr_next   = araddr_reg;
    wdata_next    = wdata_reg;
    gap_cnt_next  = gap_cnt_reg;
    status_next   = status_reg;
`ifdef RESET_REQ_TIMEOUT_EN
    poll_cnt_next = poll_cnt_reg;
`endif
    case (state_reg)
      S_IDLE: begin
        if (req_valid) begin
          wdata_next    = {28'b0, req_domain, 1'b1};
          awaddr_next   = AW'(CTRL_ADDR);
          araddr_next   = AW'(STATUS_ADDR);
          aw_done_next  = 1'b0;
          w_done_next   = 1'b0;
`ifdef RESET_REQ_TIMEOUT_EN
          poll_cnt_next = '0;
`endif
          state_next    = S_WRITE;
        end
      end
      S_WRITE: begin
        // AW and W complete independently; leave only once both have fired.
        if (aw_fire) aw_done_next = 1'b1;
        if (w_fire)  w_done_next  = 1'b1;
        if ((aw_done_reg || aw_fire) && (w_done_reg || w_fire)) state_next = S_BRESP;
      end
      S_BRESP: begin
        if (m00_axi.bvalid) begin
          if (m00_axi.bresp[1]) begin
            status_next = ST_WR_ERR;
            state_next  = S_DONE;
          end else begin
            state_next  = S_READ;
          end
        end
      end
      S_READ: begin
        if (m00_axi.arready) begin
`ifdef RESET_REQ_TIMEOUT_EN
          poll_cnt_next = poll_cnt_reg + POLL_W'(1);
`endif
          state_next = S_RDATA;
        end
      end
      S_RDATA: begin
        if (m00_axi.rvalid) begin
          if (m00_axi.rresp[1]) begin
            status_next = ST_RD_ERR;
            state_next  = S_DONE;
          end else if (!m00_axi.rdata[0]) begin
            status_next = ST_OK;
            state_next  = S_DONE;
          end else begin
            gap_cnt_next = '0;
            state_next   = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_reg == GAP_W'(POLL_GAP - 1)) begin
`ifdef RESET_REQ_TIMEOUT_EN
          if (poll_cnt_reg >= POLL_W'(POLL_LIMIT)) begin
            status_next = ST_TIMEOUT;
            state_next  = S_DONE;
          end else begin
            state_next  = S_READ;
          end
`else
          state_next = S_READ;
`endif
        end else begin
          gap_cnt_next = gap_cnt_reg + GAP_W'(1);
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign req_ready   = (state_reg == S_IDLE);
  assign done_valid  = (state_reg == S_DONE);
  assign done_status = status_reg;

  assign m00_axi.awaddr  = awaddr_reg;
  assign m00_axi.awprot  = 3'b000;
  assign m00_axi.awvalid = awvalid_int;
  assign m00_axi.wdata   = wdata_reg;
  assign m00_axi.wstrb   = 4'hF;
  assign m00_axi.wvalid  = wvalid_int;
  assign m00_axi.bready  = (state_reg == S_BRESP);
  assign m00_axi.araddr  = araddr_reg;
  assign m00_axi.arprot  = 3'b000;
  assign m00_axi.arvalid = arvalid_int;
  assign m00_axi.rready  = (state_reg == S_RDATA);

  // Only the error bit of each response and the busy bit of status matter.
  logic unused_bits;
  assign unused_bits = ^{m00_axi.bresp[0], m00_axi.rresp[0], m00_axi.rdata[31:1]};

endmodule

// File: tb/tb_reset_request_axi_master.sv
// Randomised bench for reset_request_axi_master: reactive AXI-Lite slave model,
// expected completions queued at issue time and checked by an independent monitor.
`timescale 1ns/1ps
module tb_reset_request_axi_master;

  localparam int          G     = 4;
  localparam int          LIMIT = 8;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] CTRL  = 32'h0;
  localparam logic [31:0] STAT  = 32'h4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [2:0] req_domain = 3'd0;
  logic       req_ready, done_valid;
  logic [1:0] done_status;

  always #5 clk = ~clk;

  reset_request_axi_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  reset_request_axi_master #(
    .C_M00_AXI_ADDR_WIDTH(32), .C_M00_AXI_DATA_WIDTH(32),
    .BASE_ADDR(BASE), .CTRL_OFFSET(CTRL), .STATUS_OFFSET(STAT),
    .POLL_GAP(G), .POLL_LIMIT(LIMIT)
  ) dut (
    .m00_axi_aclk(clk), .m00_axi_aresetn(rst_n),
    .req_valid(req_valid), .req_domain(req_domain), .req_ready(req_ready),
    .done_valid(done_valid), .done_status(done_status),
    .m00_axi(axi)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  status;
    logic [31:0] wdata;
    int          reads;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  // Reference: walk the polls in order and apply the first rule that ends the request.
  function automatic exp_t model(input logic [2:0] dom, input logic [1:0] bresp,
                                 input int busy, input int errp, input bit zero_wait);
    exp_t e;
    int   gaps;
    e.wdata  = {28'b0, dom, 1'b1};
    e.status = 2'b00;
    e.reads  = 0;
    gaps     = 0;
    if (bresp[1]) begin
      e.status = 2'b01;
    end else begin
      for (int k = 1; k <= 10000; k++) begin
        e.reads = k;
        if (k == errp)     begin e.status = 2'b10; gaps = k - 1; break; end
        if (k > busy)      begin e.status = 2'b00; gaps = k - 1; break; end
`ifdef RESET_REQ_TIMEOUT_EN
        if (k >= LIMIT)    begin e.status = 2'b11; gaps = k;     break; end
`endif
      end
    end
    if (!zero_wait)       e.lat = -1;
    else if (bresp[1])    e.lat = 3;
    else                  e.lat = 3 + 2 * e.reads + gaps * G;
    return e;
  endfunction

  // Slave configuration (per request) and state.
  int         cfg_aw_d = 0, cfg_w_d = 0, cfg_b_d = 0, cfg_ar_d = 0, cfg_r_d = 0;
  logic [1:0] cfg_bresp = 2'b00, cfg_rerr = 2'b10;
  int         cfg_busy = 0, cfg_errp = 0;
  int         s_aw_cnt, s_w_cnt, s_ar_cnt, s_b_cnt, s_r_cnt, poll_idx;
  bit         got_aw, got_w, pend_r;
  bit         aw_hs, w_hs, b_hs, ar_hs, r_hs, awv, wv, arv;

  task automatic slave_clear();
    s_aw_cnt = 0; s_w_cnt = 0; s_ar_cnt = 0; s_b_cnt = 0; s_r_cnt = 0;
    got_aw = 0; got_w = 0; pend_r = 0;
    axi.awready = 0; axi.wready = 0; axi.arready = 0;
    axi.bvalid = 0; axi.bresp = 0; axi.rvalid = 0; axi.rdata = 0; axi.rresp = 0;
  endtask

  initial begin
    logic [31:0] rnd;
    slave_clear();
    poll_idx = 0;
    forever begin
      @(negedge clk);
      aw_hs = axi.awvalid && axi.awready;  awv = axi.awvalid;
      w_hs  = axi.wvalid  && axi.wready;   wv  = axi.wvalid;
      ar_hs = axi.arvalid && axi.arready;  arv = axi.arvalid;
      b_hs  = axi.bvalid  && axi.bready;
      r_hs  = axi.rvalid  && axi.rready;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        slave_clear();
        continue;
      end
      if (aw_hs) begin got_aw = 1; s_aw_cnt = 0; end else if (awv) s_aw_cnt++;
      if (w_hs)  begin got_w  = 1; s_w_cnt  = 0; end else if (wv)  s_w_cnt++;
      if (ar_hs) s_ar_cnt = 0; else if (arv) s_ar_cnt++;
      axi.awready = (s_aw_cnt >= cfg_aw_d);
      axi.wready  = (s_w_cnt  >= cfg_w_d);
      axi.arready = (s_ar_cnt >= cfg_ar_d);
      if (b_hs) begin
        axi.bvalid = 0; got_aw = 0; got_w = 0; s_b_cnt = 0;
      end else if (got_aw && got_w && !axi.bvalid) begin
        if (s_b_cnt >= cfg_b_d) begin axi.bvalid = 1; axi.bresp = cfg_bresp; end
        else s_b_cnt++;
      end
      if (r_hs) begin axi.rvalid = 0; pend_r = 0; end
      if (ar_hs) begin pend_r = 1; s_r_cnt = 0; poll_idx++; end
      if (pend_r && !axi.rvalid) begin
        if (s_r_cnt >= cfg_r_d) begin
          rnd        = $urandom;
          axi.rvalid = 1;
          axi.rdata  = {rnd[31:1], (poll_idx <= cfg_busy) ? 1'b1 : 1'b0};
          axi.rresp  = (poll_idx == cfg_errp) ? cfg_rerr : 2'b00;
        end else s_r_cnt++;
      end
    end
  end

  // Monitor: observes the bus and the completion port, pops expectations on done.
  int         done_cnt = 0;
  int         lat = 0, m_aw = 0, m_w = 0, m_rd = 0, gap_cnt = 0;
  bit         in_txn = 0, gap_pend = 0, after_done = 0;
  logic [31:0] m_wdata = 0;
  logic [1:0]  last_status = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_txn = 0; gap_pend = 0; after_done = 0;
        continue;
      end
      if (after_done) begin
        check("req_ready_after_done", {31'b0, req_ready}, 1);
        check("done_one_cycle", {31'b0, done_valid}, 0);
        check("status_hold", {30'b0, done_status}, {30'b0, last_status});
        after_done = 0;
      end
      if (in_txn) lat++;
      if (axi.awvalid && axi.awready) begin
        m_aw++;
        check("awaddr", axi.awaddr, BASE + CTRL);
      end
      if (axi.wvalid && axi.wready) begin
        m_w++;
        m_wdata = axi.wdata;
        check("wstrb", {28'b0, axi.wstrb}, 32'hF);
      end
      if (axi.arvalid && axi.arready) begin
        m_rd++;
        check("araddr", axi.araddr, BASE + STAT);
      end
      if (gap_pend) begin
        if (axi.arvalid) begin
          check("poll_gap", gap_cnt, G);
          gap_pend = 0;
        end else gap_cnt++;
      end
      if (axi.rvalid && axi.rready && !axi.rresp[1] && axi.rdata[0]) begin
        gap_pend = 1; gap_cnt = 0;
      end
      if (done_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got status %b expected no completion", done_status);
        end else begin
          e = exp_q.pop_front();
          check("done_status", {30'b0, done_status}, {30'b0, e.status});
          check("wdata", m_wdata, e.wdata);
          check("aw_beats", m_aw, 1);
          check("w_beats", m_w, 1);
          check("read_count", m_rd, e.reads);
          if (e.lat >= 0) check("latency", lat, e.lat);
          $display("txn %0d: status=%b wdata=%h reads=%0d latency=%0d", done_cnt,
                   done_status, m_wdata, m_rd, lat);
        end
        in_txn = 0; gap_pend = 0; after_done = 1; last_status = done_status;
        done_cnt++;
      end
      if (req_valid && req_ready) begin
        in_txn = 1; lat = 0; m_aw = 0; m_w = 0; m_rd = 0;
      end
    end
  end

  task automatic issue_req(input logic [2:0] dom, input int awd, input int wd, input int bd,
                           input int ard, input int rd, input logic [1:0] bresp,
                           input int busy, input int errp, input bit junk, input bit expect_done);
    cfg_aw_d = awd; cfg_w_d = wd; cfg_b_d = bd; cfg_ar_d = ard; cfg_r_d = rd;
    cfg_bresp = bresp; cfg_busy = busy; cfg_errp = errp;
    poll_idx = 0;
    if (expect_done)
      exp_q.push_back(model(dom, bresp, busy, errp, (awd | wd | bd | ard | rd) == 0));
    @(posedge clk); #1;
    req_valid = 1; req_domain = dom;
    @(posedge clk); #1;
    if (junk) begin
      req_domain = ~dom;
      repeat (2) @(posedge clk);
      #1;
    end
    req_valid = 0;
  endtask

  task automatic wait_done(input int start);
    for (int i = 0; i < 3000 && done_cnt == start; i++) @(posedge clk);
    if (done_cnt == start) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: got no done_valid expected completion within 3000 cycles");
      exp_q.delete();
    end
  endtask

  task automatic do_req(input logic [2:0] dom, input int awd, input int wd, input int bd,
                        input int ard, input int rd, input logic [1:0] bresp,
                        input int busy, input int errp, input bit junk);
    int start;
    start = done_cnt;
    issue_req(dom, awd, wd, bd, ard, rd, bresp, busy, errp, junk, 1'b1);
    wait_done(start);
  endtask

  initial begin
    int busy, errp, r;
    logic [1:0] br;
    bit seen;

    #12;
    check("rst_req_ready", {31'b0, req_ready}, 1);
    check("rst_done_valid", {31'b0, done_valid}, 0);
    check("rst_done_status", {30'b0, done_status}, 0);
    check("rst_valids", {28'b0, axi.awvalid, axi.wvalid, axi.arvalid, 1'b0}, 0);
    check("rst_readys", {30'b0, axi.bready, axi.rready}, 0);
    check("rst_awaddr", axi.awaddr, 0);
    check("rst_araddr", axi.araddr, 0);
    check("rst_wdata", axi.wdata, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;

    do_req(3'd5, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);          // minimum latency
    do_req(3'd2, 3, 0, 0, 0, 0, 2'b00, 0, 0, 0);          // W before AW
    do_req(3'd6, 0, 3, 1, 0, 0, 2'b00, 0, 0, 0);          // AW before W
    do_req(3'd1, 0, 0, 0, 0, 0, 2'b00, 3, 0, 0);          // three busy polls
    do_req(3'd4, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0);          // write error
    cfg_rerr = 2'b10;
    do_req(3'd7, 0, 0, 0, 0, 0, 2'b00, 5, 2, 0);          // read error, second poll
`ifdef RESET_REQ_TIMEOUT_EN
    do_req(3'd3, 0, 0, 0, 0, 0, 2'b00, 1000, 0, 0);       // timeout
`endif

    // Reset while waiting in READ: outputs drop at once, next request is clean.
    issue_req(3'd6, 0, 0, 0, 40, 0, 2'b00, 0, 0, 0, 1'b0);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = axi.arvalid;
    end
    check("reached_read", {31'b0, seen}, 1);
    #2 rst_n = 0;
    #1;
    check("midrst_valids", {29'b0, axi.awvalid, axi.wvalid, axi.arvalid}, 0);
    check("midrst_readys", {30'b0, axi.bready, axi.rready}, 0);
    check("midrst_done_valid", {31'b0, done_valid}, 0);
    check("midrst_req_ready", {31'b0, req_ready}, 1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1;
    do_req(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      r  = $urandom_range(0, 9);
      br = (r < 2) ? (($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10) : (r == 2) ? 2'b01 : 2'b00;
`ifdef RESET_REQ_TIMEOUT_EN
      busy = $urandom_range(0, 10);
`else
      busy = $urandom_range(0, 3);
`endif
      errp     = ($urandom_range(0, 4) == 0) ? $urandom_range(1, busy + 1) : 0;
      cfg_rerr = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10;
      if ($urandom_range(0, 2) == 0)
        do_req(3'($urandom_range(0, 7)), 0, 0, 0, 0, 0, br, busy, errp,
               $urandom_range(0, 1) != 0);
      else
        do_req(3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               br, busy, errp, $urandom_range(0, 1) != 0);
    end

    repeat (5) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
